// File: rtl/fsk_pkg.sv
// Shared constants, state encoding and helper functions for the FSK receive framer.
package fsk_pkg;

    localparam int DATA_BITS            = 12;
    localparam int FRAME_BITS           = 15;
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    localparam int PERR_IDX = 0;
    localparam int FERR_IDX = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } fsk_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] v);
        return ^v;
    endfunction

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/fsk_rx_line_filter.sv
// Two-flop synchroniser followed by a 3-sample majority vote; a single-cycle
// glitch never wins the vote, and a clean edge reaches q four cycles later.
module fsk_rx_line_filter
    import fsk_pkg::*;
(
    input  logic sysclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic       s1_r;
    logic       s2_r;
    logic [2:0] hist_r;

    // Synchroniser and history shift, all resetting to the idle-high level
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r   <= 1'b1;
            s2_r   <= 1'b1;
            hist_r <= 3'b111;
        end else begin
            s1_r   <= d;
            s2_r   <= s1_r;
            hist_r <= {hist_r[1:0], s2_r};
        end
    end

    assign q = maj3(hist_r);

endmodule

// File: rtl/fsk_rx_framer.sv
// Frames 12-bit words (start, 12 data LSB first, even parity, stop) out of the
// filtered demodulator line and reports each word with a one-cycle strobe.
module fsk_rx_framer
    import fsk_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
)
(
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 signal_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic [1:0]           rx_status,
    output logic                 rx_busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] BIDX_ZERO = {BIDX_W{1'b0}};
    localparam logic [BIDX_W-1:0] BIDX_ONE  = BIDX_W'(1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

    logic                 filt_s;
    fsk_state_t           state_r,  nxt_state_s;
    logic [CNT_W-1:0]     cnt_r,    nxt_cnt_s;
    logic [BIDX_W-1:0]    bidx_r,   nxt_bidx_s;
    logic [DATA_BITS-1:0] shreg_r,  nxt_shreg_s;
    logic                 par_r,    nxt_par_s;
    logic                 stop_r,   nxt_stop_s;
    logic                 done_r,   nxt_done_s;
    logic [1:0]           status_s;

    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic [1:0]           rx_status_r;
    logic                 rx_busy_r;

    fsk_rx_line_filter u_filter (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .d      (signal_in),
        .q      (filt_s)
    );

    // Frame state register and bit-timing counters
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            bidx_r  <= BIDX_ZERO;
            shreg_r <= {DATA_BITS{1'b0}};
            par_r   <= 1'b0;
            stop_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
            bidx_r  <= nxt_bidx_s;
            shreg_r <= nxt_shreg_s;
            par_r   <= nxt_par_s;
            stop_r  <= nxt_stop_s;
            done_r  <= nxt_done_s;
        end
    end

    // Next-state logic: counters restart whenever a sample point is taken
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r + CNT_ONE;
        nxt_bidx_s  = bidx_r;
        nxt_shreg_s = shreg_r;
        nxt_par_s   = par_r;
        nxt_stop_s  = stop_r;
        nxt_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                nxt_cnt_s = CNT_ZERO;
                if (filt_s == 1'b0) nxt_state_s = START;
                else                nxt_state_s = IDLE;
            end
            START: begin
                if (cnt_r == CNT_MID) begin
                    nxt_cnt_s = CNT_ZERO;
                    if (filt_s == 1'b1) begin
                        nxt_state_s = IDLE;
                    end else begin
                        nxt_state_s = DATA;
                        nxt_bidx_s  = BIDX_ZERO;
                    end
                end else begin
                    nxt_state_s = START;
                end
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    nxt_cnt_s           = CNT_ZERO;
                    nxt_shreg_s[bidx_r] = filt_s;
                    if (bidx_r == BIDX_LAST) nxt_state_s = PARITY;
                    else                     nxt_bidx_s  = bidx_r + BIDX_ONE;
                end else begin
                    nxt_state_s = DATA;
                end
            end
            PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    nxt_cnt_s   = CNT_ZERO;
                    nxt_par_s   = filt_s;
                    nxt_state_s = STOP;
                end else begin
                    nxt_state_s = PARITY;
                end
            end
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    nxt_cnt_s   = CNT_ZERO;
                    nxt_stop_s  = filt_s;
                    nxt_done_s  = 1'b1;
                    nxt_state_s = filt_s ? IDLE : BREAK;
                end else begin
                    nxt_state_s = STOP;
                end
            end
            BREAK: begin
                // a low line here is a break, never a start bit
                nxt_cnt_s = CNT_ZERO;
                if (filt_s == 1'b1) nxt_state_s = IDLE;
                else                nxt_state_s = BREAK;
            end
            default: begin
                nxt_state_s = IDLE;
                nxt_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Status flags of the frame just completed
    always_comb begin
        status_s           = 2'b00;
        status_s[PERR_IDX] = even_parity(shreg_r) ^ par_r;
        status_s[FERR_IDX] = ~stop_r;
    end

    // Registered outputs; word and status are published one cycle after the stop sample
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r   <= {DATA_BITS{1'b0}};
            rx_valid_r  <= 1'b0;
            rx_status_r <= 2'b00;
            rx_busy_r   <= 1'b0;
        end else begin
            rx_valid_r <= done_r;
            rx_busy_r  <= (nxt_state_s != IDLE);
            if (done_r) begin
                rx_data_r   <= shreg_r;
                rx_status_r <= status_s;
            end else begin
                rx_data_r   <= rx_data_r;
                rx_status_r <= rx_status_r;
            end
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign rx_status = rx_status_r;
    assign rx_busy   = rx_busy_r;

endmodule

// File: tb/tb_fsk_rx_framer.sv
// Self-checking bench for fsk_rx_framer: a vector table of frames plus
// hand-written glitch, break and mid-frame reset sequences, with a scoreboard.
module tb_fsk_rx_framer;

    localparam int C   = 16;
    // edges from driving the start bit to rx_valid: 4 filter + 1 FSM read + 233
    localparam int LAT = 4 + 1 + 14 * C + C / 2 + 1;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        signal_in;
    logic [11:0] rx_data;
    logic        rx_valid;
    logic [1:0]  rx_status;
    logic        rx_busy;

    typedef struct packed {
        logic [11:0] d;
        logic [1:0]  s;
    } exp_t;

    typedef struct {
        logic [11:0] data;
        logic        pbit;
        logic        stopb;
        int          gap;
        logic [11:0] exp_data;
        logic [1:0]  exp_status;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   valid_cnt = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   t_start = 0;

    fsk_rx_framer #(.CLKS_PER_BIT(C)) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .signal_in (signal_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_status (rx_status),
        .rx_busy   (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // scoreboard: every rx_valid must match the oldest pending expectation
    always begin
        @(posedge sysclk);
        #1;
        if (rst_n === 1'b1 && rx_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: rx_valid=1 with rx_data=0x%0h, no frame pending", rx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.d));
                check("rx_status", 32'(rx_status), 32'(e.s));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_bit(input logic b);
        signal_in = b;
        idle(C);
    endtask

    task automatic send_frame(input logic [11:0] data, input logic pbit, input logic stopb,
                              input int gap, input logic [11:0] exp_d, input logic [1:0] exp_s);
        exp_t e;
        e.d = exp_d;
        e.s = exp_s;
        exp_q.push_back(e);
        t_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 12; i++) send_bit(data[i]);
        send_bit(pbit);
        send_bit(stopb);
        signal_in = 1'b1;
        idle(gap);
    endtask

    initial begin
        int   seen_busy;
        int   vc0;
        logic [11:0] part;

        vecs[0] = '{12'hF0C, 1'b0, 1'b1,  8, 12'hF0C, 2'b00};
        vecs[1] = '{12'hC3C, 1'b0, 1'b1,  8, 12'hC3C, 2'b00};
        vecs[2] = '{12'h001, 1'b0, 1'b1, 16, 12'h001, 2'b01};
        vecs[3] = '{12'hFFF, 1'b0, 1'b1, 16, 12'hFFF, 2'b00};
        vecs[4] = '{12'h0F0, 1'b0, 1'b0, 32, 12'h0F0, 2'b10};
        vecs[5] = '{12'h003, 1'b1, 1'b0, 32, 12'h003, 2'b11};
        vecs[6] = '{12'h800, 1'b1, 1'b1, 16, 12'h800, 2'b00};

        rst_n     = 1'b0;
        signal_in = 1'b1;
        idle(3);
        check("reset_data",   32'(rx_data),   32'h0);
        check("reset_valid",  32'(rx_valid),  32'h0);
        check("reset_status", 32'(rx_status), 32'h0);
        check("reset_busy",   32'(rx_busy),   32'h0);
        rst_n = 1'b1;
        idle(5);

        // first frame with start-to-valid latency
        send_frame(12'hAAA, 1'b0, 1'b1, 8, 12'hAAA, 2'b00);
        check("latency", 32'(last_valid_cyc - t_start), 32'(LAT));

        for (int i = 0; i < 7; i++)
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stopb, vecs[i].gap,
                       vecs[i].exp_data, vecs[i].exp_status);

        // 1-cycle glitch never reaches the framer
        seen_busy = 0;
        signal_in = 1'b0;
        idle(1);
        signal_in = 1'b1;
        repeat (20) begin
            @(negedge sysclk);
            if (rx_busy) seen_busy = 1;
        end
        check("glitch1_busy", 32'(seen_busy), 32'd0);

        // 4-cycle pulse: start detected, then rejected at mid start bit
        vc0 = valid_cnt;
        seen_busy = 0;
        signal_in = 1'b0;
        idle(4);
        signal_in = 1'b1;
        repeat (8) begin
            @(negedge sysclk);
            if (rx_busy) seen_busy = 1;
        end
        check("glitch4_busy_rise", 32'(seen_busy), 32'd1);
        idle(2 * C);
        check("glitch4_busy_drop", 32'(rx_busy), 32'd0);
        check("glitch4_no_valid", 32'(valid_cnt - vc0), 32'd0);

        // line held low for 40 bit periods: one framing-error word, busy until release
        vc0 = valid_cnt;
        exp_q.push_back(exp_t'{12'h000, 2'b10});
        signal_in = 1'b0;
        idle(300);
        check("break_busy_mid", 32'(rx_busy), 32'd1);
        idle(40 * C - 300);
        signal_in = 1'b1;
        check("break_busy_at_release", 32'(rx_busy), 32'd1);
        idle(8);
        check("break_busy_after", 32'(rx_busy), 32'd0);
        check("break_one_valid", 32'(valid_cnt - vc0), 32'd1);
        idle(8);
        send_frame(12'h5A5, 1'b0, 1'b1, 16, 12'h5A5, 2'b00);

        // reset in the middle of data bit 6 of 0x123
        vc0 = valid_cnt;
        part = 12'h123;
        send_bit(1'b0);
        for (int i = 0; i < 6; i++) send_bit(part[i]);
        signal_in = part[6];
        idle(C / 2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_data",   32'(rx_data),   32'h0);
        check("rst_mid_status", 32'(rx_status), 32'h0);
        check("rst_mid_busy",   32'(rx_busy),   32'h0);
        check("rst_mid_valid",  32'(rx_valid),  32'h0);
        signal_in = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(3 * C);
        check("rst_no_valid", 32'(valid_cnt - vc0), 32'd0);
        check("rst_idle_busy", 32'(rx_busy), 32'd0);
        send_frame(12'h456, 1'b1, 1'b1, 16, 12'h456, 2'b00);

        // bounded drain of any outstanding expectation
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge sysclk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("valid_total", 32'(valid_cnt), 32'd11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
